coef_ram_loader: RTL and testbench
==================================

# coef_ram_loader

Writer side of the coefficient RAM and the processing-parameter registers consumed by the audio DSP channels. Accepts a framed byte stream (one byte per `rx_valid` strobe, e.g. from the host UART receiver) and does two things: writes 8-bit coefficients into the 128-entry coefficient RAM through its write port, and updates the `Nfreq`/`Nquant` parameters driven to the DSP. It validates framing, length, checksum and inter-byte timeout, and reports status to the host/control logic.

## Interface
- `TIMEOUT_CYCLES`, 1000000: maximum clock cycles allowed between consecutive bytes of a frame.
- `NFREQ_RST`, 4'd0: reset value of `Nfreq`.
- `NQUANT_RST`, 5'd18: reset value of `Nquant`.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  received byte, valid when `rx_valid`=1.
- `rx_valid`  in  1  single-cycle byte strobe.
- `RAM_coefs_wr_addr`  out  7  coefficient RAM write address.
- `RAM_coefs_datain`  out  8  coefficient RAM write data.
- `RAM_coefs_wen`  out  1  RAM write enable, one cycle per byte.
- `Nfreq`  out  4  frequency-select parameter to the DSP.
- `Nquant`  out  5  quantisation parameter to the DSP.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse: frame accepted.
- `error`  out  1  one-cycle pulse: frame rejected.
- `err_code`  out  2  0 none, 1 checksum, 2 bad cmd/len/param, 3 timeout; held.

## Operation
- Frame formats. All checksums are the XOR of every byte after SYNC, up to but not including CK.
  - Coefficient load: `A5`, `01`, LEN, ADDR, D[0..LEN-1], CK.
  - Parameter set: `A5`, `02`, F, Q, CK.
- FSM states: IDLE, CMD, LEN, ADDR, DATA, PF, PQ, CSUM.
  - IDLE: bytes other than `A5` are ignored. On `A5`: go to CMD, set `busy`, clear `err_code`, clear the running XOR.
  - CMD: `01` goes to LEN, `02` goes to PF. Any other value: error code 2, return to IDLE.
  - LEN: valid range 1..128 (encoding 0 and >128 invalid). Invalid value: error code 2, return to IDLE. Valid: load the byte counter, go to ADDR.
  - ADDR: only `ADDR[6:0]` is used (bit 7 ignored). Load the write pointer, go to DATA.
  - DATA: each byte produces one RAM write, then the pointer increments and wraps 127→0. After LEN bytes, go to CSUM.
  - PF: `F[3:0]` goes to a shadow register; bits 7:4 must be 0, otherwise error code 2. Go to PQ.
  - PQ: `Q[4:0]` goes to a shadow register; the value must be ≤18, otherwise error code 2. Go to CSUM.
  - CSUM: on match, pulse `done`; for a parameter frame, also copy the shadows to `Nfreq`/`Nquant` that same cycle. On mismatch, `error` with code 1; parameters stay unchanged. Always return to IDLE.
- Coefficient writes are committed as bytes arrive. A checksum, timeout or abort after DATA does not undo them; the host must resend the frame.
- Timeout: the counter resets on every `rx_valid`. If it reaches `TIMEOUT_CYCLES` in any state other than IDLE: `error` with code 3, return to IDLE.
- If `A5` arrives mid-frame, it is treated as a data or field byte, not as a resync.
- Reset mid-frame: the FSM goes to IDLE immediately and all outputs return to their reset values. RAM contents are not touched.

## Timing
- Reset values:
  - `RAM_coefs_wr_addr`=0, `RAM_coefs_datain`=0, `RAM_coefs_wen`=0.
  - `Nfreq`=`NFREQ_RST`, `Nquant`=`NQUANT_RST`.
  - `busy`=0, `done`=0, `error`=0, `err_code`=0.
- All outputs are registered.
- RAM write: `rx_valid` with a DATA byte in cycle t gives `RAM_coefs_wen`=1 in cycle t+1, with that byte's address and data. `addr`/`datain` hold their values after `wen` drops.
- `busy` rises in the cycle after SYNC is sampled. It falls in the same cycle as the `done`/`error` pulse, which is the cycle after the terminating byte.
- `Nfreq`/`Nquant` update in the cycle of the `done` pulse and are stable at all other times.
- `done` and `error` are mutually exclusive and each lasts exactly one cycle.
- Back-to-back `rx_valid` on consecutive cycles is supported at full rate.
- When the timeout and `rx_valid` coincide in the same cycle, the byte wins and no timeout is raised.

## Test plan
- Coefficient load, start address 0x10: `A5 01 04 10 11 22 33 44 CK` (CK=01^04^10^11^22^33^44) → four `wen` pulses at addresses 0x10..0x13 with data 11,22,33,44; then `done`; `err_code`=0.
- Address wrap: LEN=3, ADDR=0x7F, data AA BB CC, correct CK → writes at addresses 7F, 00, 01; `done`.
- Parameter frame `A5 02 05 0C 0B` → `Nfreq`=5 and `Nquant`=12 in the `done` cycle. A second frame with a wrong CK → `error`, `err_code`=1, parameters stay 5/12.
- Bad fields:
  - CMD=`03` → `error`, code 2, `busy` low.
  - LEN=0 or LEN=0x81 → code 2, no `wen`.
  - Q=19 → code 2.
- Stall after two DATA bytes for `TIMEOUT_CYCLES` (shrunk to 100 in the bench) → `error` with code 3 at cycle 100; both writes already visible. A valid frame sent afterwards → `done`.
- Assert `reset` during DATA → all outputs return to reset values the next cycle; a following valid frame completes normally.

Source files
------------

// File: rtl/coef_ram_loader.sv
// coef_ram_loader: parses framed host bytes into coefficient RAM writes and
// DSP parameter updates, checking framing, length, checksum and byte timeout.
module coef_ram_loader #(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [3:0] NFREQ_RST      = 4'd0,
  parameter logic [4:0] NQUANT_RST     = 5'd18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] RAM_coefs_wr_addr,
  output logic [7:0] RAM_coefs_datain,
  output logic       RAM_coefs_wen,
  output logic [3:0] Nfreq,
  output logic [4:0] Nquant,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD  = 3'd1;
  localparam logic [2:0] LEN  = 3'd2;
  localparam logic [2:0] ADDR = 3'd3;
  localparam logic [2:0] DATA = 3'd4;
  localparam logic [2:0] PF   = 3'd5;
  localparam logic [2:0] PQ   = 3'd6;
  localparam logic [2:0] CSUM = 3'd7;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_COEF  = 8'h01;
  localparam logic [7:0] CMD_PARAM = 8'h02;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_FIELD   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       r_state;
  logic [7:0]       r_xor;
  logic [7:0]       r_remain;
  logic [6:0]       r_ptr;
  logic [3:0]       r_fShadow;
  logic [4:0]       r_qShadow;
  logic             r_isParam;
  logic [CNT_W-1:0] r_toCnt;

  logic [6:0] r_wrAddr;
  logic [7:0] r_datain;
  logic       r_wen;
  logic [3:0] r_nfreq;
  logic [4:0] r_nquant;
  logic       r_busy;
  logic       r_done;
  logic       r_error;
  logic [1:0] r_errCode;

  logic w_timeout;
  logic w_lenOk;

  // A received byte always beats an expiring timer in the same cycle.
  assign w_timeout = (r_state != IDLE) && !rx_valid && (r_toCnt == CNT_LAST);
  // Lengths 1..128 are legal; 0 would be a zero-byte load.
  assign w_lenOk   = (rx_data != 8'd0) && (rx_data <= 8'd128);

  // Frame parser, timeout supervisor and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_xor     <= 8'd0;
      r_remain  <= 8'd0;
      r_ptr     <= 7'd0;
      r_fShadow <= 4'd0;
      r_qShadow <= 5'd0;
      r_isParam <= 1'b0;
      r_toCnt   <= '0;
      r_wrAddr  <= 7'd0;
      r_datain  <= 8'd0;
      r_wen     <= 1'b0;
      r_nfreq   <= NFREQ_RST;
      r_nquant  <= NQUANT_RST;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_errCode <= ERR_NONE;
    end else begin
      r_wen   <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;

      if (rx_valid || (r_state == IDLE)) begin
        r_toCnt <= '0;
      end else begin
        r_toCnt <= r_toCnt + CNT_W'(1);
      end

      if (w_timeout) begin
        r_error   <= 1'b1;
        r_errCode <= ERR_TIMEOUT;
        r_busy    <= 1'b0;
        r_state   <= IDLE;
      end else if (rx_valid) begin
        if ((r_state != IDLE) && (r_state != CSUM)) begin
          r_xor <= r_xor ^ rx_data;
        end
        case (r_state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              r_state   <= CMD;
              r_busy    <= 1'b1;
              r_errCode <= ERR_NONE;
              r_xor     <= 8'd0;
            end
          end
          CMD: begin
            if (rx_data == CMD_COEF) begin
              r_isParam <= 1'b0;
              r_state   <= LEN;
            end else if (rx_data == CMD_PARAM) begin
              r_isParam <= 1'b1;
              r_state   <= PF;
            end else begin
              r_error   <= 1'b1;
              r_errCode <= ERR_FIELD;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end
          end
          LEN: begin
            if (w_lenOk) begin
              r_remain <= rx_data;
              r_state  <= ADDR;
            end else begin
              r_error   <= 1'b1;
              r_errCode <= ERR_FIELD;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end
          end
          ADDR: begin
            r_ptr   <= rx_data[6:0];
            r_state <= DATA;
          end
          DATA: begin
            r_wen    <= 1'b1;
            r_wrAddr <= r_ptr;
            r_datain <= rx_data;
            r_ptr    <= r_ptr + 7'd1;
            r_remain <= r_remain - 8'd1;
            if (r_remain == 8'd1) begin
              r_state <= CSUM;
            end
          end
          PF: begin
            r_fShadow <= rx_data[3:0];
            if (rx_data[7:4] == 4'd0) begin
              r_state <= PQ;
            end else begin
              r_error   <= 1'b1;
              r_errCode <= ERR_FIELD;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end
          end
          PQ: begin
            r_qShadow <= rx_data[4:0];
            if (rx_data <= 8'd18) begin
              r_state <= CSUM;
            end else begin
              r_error   <= 1'b1;
              r_errCode <= ERR_FIELD;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end
          end
          CSUM: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
            if (rx_data == r_xor) begin
              r_done <= 1'b1;
              if (r_isParam) begin
                r_nfreq  <= r_fShadow;
                r_nquant <= r_qShadow;
              end
            end else begin
              r_error   <= 1'b1;
              r_errCode <= ERR_CSUM;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign RAM_coefs_wr_addr = r_wrAddr;
  assign RAM_coefs_datain  = r_datain;
  assign RAM_coefs_wen     = r_wen;
  assign Nfreq             = r_nfreq;
  assign Nquant            = r_nquant;
  assign busy              = r_busy;
  assign done              = r_done;
  assign error             = r_error;
  assign err_code          = r_errCode;

endmodule

// File: tb/tb_coef_ram_loader.sv
// tb_coef_ram_loader: directed frames with hand-computed expectations for
// coef_ram_loader; timeout shrunk to 100 cycles.
module tb_coef_ram_loader;

   logic       clock;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [6:0] RAM_coefs_wr_addr;
   logic [7:0] RAM_coefs_datain;
   logic       RAM_coefs_wen;
   logic [3:0] Nfreq;
   logic [4:0] Nquant;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] err_code;

   int compared;
   int mismatched;

   coef_ram_loader #(
      .TIMEOUT_CYCLES(100),
      .NFREQ_RST(4'd0),
      .NQUANT_RST(5'd18)
   ) dut (
      .clock(clock),
      .reset(reset),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .RAM_coefs_wr_addr(RAM_coefs_wr_addr),
      .RAM_coefs_datain(RAM_coefs_datain),
      .RAM_coefs_wen(RAM_coefs_wen),
      .Nfreq(Nfreq),
      .Nquant(Nquant),
      .busy(busy),
      .done(done),
      .error(error),
      .err_code(err_code)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Present one byte for one rising edge, starting and ending on a falling edge.
   task automatic applyStimulus(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Check the full set of outputs against their reset values.
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_addr"}, 32'(RAM_coefs_wr_addr), 32'h00);
      checkOutput({tag, "_datain"}, 32'(RAM_coefs_datain), 32'h00);
      checkOutput({tag, "_wen"}, 32'(RAM_coefs_wen), 32'h0);
      checkOutput({tag, "_nfreq"}, 32'(Nfreq), 32'h0);
      checkOutput({tag, "_nquant"}, 32'(Nquant), 32'd18);
      checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
      checkOutput({tag, "_done"}, 32'(done), 32'h0);
      checkOutput({tag, "_error"}, 32'(error), 32'h0);
      checkOutput({tag, "_errcode"}, 32'(err_code), 32'h0);
   endtask

   // Send one data byte and check the RAM write it produces.
   task automatic sendData(input string tag, input logic [7:0] b, input logic [6:0] expAddr);
      applyStimulus(b);
      checkOutput({tag, "_wen"}, 32'(RAM_coefs_wen), 32'h1);
      checkOutput({tag, "_addr"}, 32'(RAM_coefs_wr_addr), 32'(expAddr));
      checkOutput({tag, "_data"}, 32'(RAM_coefs_datain), 32'(b));
   endtask

   // Directed test sequence.
   initial begin
      int quietErrors;
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      repeat (3) @(negedge clock);
      checkResetState("reset");
      reset = 1'b0;
      @(negedge clock);

      // Coefficient load at 0x10; CK = 01^04^10^11^22^33^44 = 51
      applyStimulus(8'hA5);
      checkOutput("load_busy_rise", 32'(busy), 32'h1);
      applyStimulus(8'h01);
      applyStimulus(8'h04);
      applyStimulus(8'h10);
      sendData("load_d0", 8'h11, 7'h10);
      sendData("load_d1", 8'h22, 7'h11);
      sendData("load_d2", 8'h33, 7'h12);
      sendData("load_d3", 8'h44, 7'h13);
      applyStimulus(8'h51);
      checkOutput("load_done", 32'(done), 32'h1);
      checkOutput("load_error", 32'(error), 32'h0);
      checkOutput("load_busy_fall", 32'(busy), 32'h0);
      checkOutput("load_errcode", 32'(err_code), 32'h0);
      checkOutput("load_wen_drop", 32'(RAM_coefs_wen), 32'h0);
      checkOutput("load_addr_hold", 32'(RAM_coefs_wr_addr), 32'h13);
      @(negedge clock);
      checkOutput("load_done_one_cycle", 32'(done), 32'h0);

      // Address wrap from 7F; CK = 01^03^7F^AA^BB^CC = A0
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h03);
      applyStimulus(8'h7F);
      sendData("wrap_d0", 8'hAA, 7'h7F);
      sendData("wrap_d1", 8'hBB, 7'h00);
      sendData("wrap_d2", 8'hCC, 7'h01);
      applyStimulus(8'hA0);
      checkOutput("wrap_done", 32'(done), 32'h1);

      // Parameter frame F=5 Q=12; CK = 02^05^0C = 0B
      applyStimulus(8'hA5);
      applyStimulus(8'h02);
      applyStimulus(8'h05);
      applyStimulus(8'h0C);
      checkOutput("param_nfreq_before", 32'(Nfreq), 32'h0);
      checkOutput("param_nquant_before", 32'(Nquant), 32'd18);
      applyStimulus(8'h0B);
      checkOutput("param_done", 32'(done), 32'h1);
      checkOutput("param_nfreq", 32'(Nfreq), 32'h5);
      checkOutput("param_nquant", 32'(Nquant), 32'd12);

      // Parameter frame with wrong CK (correct would be 05)
      applyStimulus(8'hA5);
      applyStimulus(8'h02);
      applyStimulus(8'h03);
      applyStimulus(8'h04);
      applyStimulus(8'h06);
      checkOutput("badck_error", 32'(error), 32'h1);
      checkOutput("badck_done", 32'(done), 32'h0);
      checkOutput("badck_code", 32'(err_code), 32'h1);
      checkOutput("badck_nfreq", 32'(Nfreq), 32'h5);
      checkOutput("badck_nquant", 32'(Nquant), 32'd12);

      // Bad command 03; SYNC clears the held code first
      applyStimulus(8'hA5);
      checkOutput("cmd_code_cleared", 32'(err_code), 32'h0);
      applyStimulus(8'h03);
      checkOutput("cmd_error", 32'(error), 32'h1);
      checkOutput("cmd_code", 32'(err_code), 32'h2);
      checkOutput("cmd_busy", 32'(busy), 32'h0);
      @(negedge clock);
      checkOutput("cmd_error_one_cycle", 32'(error), 32'h0);
      checkOutput("cmd_code_held", 32'(err_code), 32'h2);

      // LEN = 0 and LEN = 0x81 rejected
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      checkOutput("len0_error", 32'(error), 32'h1);
      checkOutput("len0_code", 32'(err_code), 32'h2);
      applyStimulus(8'h10);
      checkOutput("len0_no_wen", 32'(RAM_coefs_wen), 32'h0);
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h81);
      checkOutput("len81_error", 32'(error), 32'h1);
      checkOutput("len81_code", 32'(err_code), 32'h2);
      applyStimulus(8'h10);
      checkOutput("len81_no_wen", 32'(RAM_coefs_wen), 32'h0);

      // Q = 19 rejected, Q = 18 (with F = F) accepted; CK = 02^0F^12 = 1F
      applyStimulus(8'hA5);
      applyStimulus(8'h02);
      applyStimulus(8'h01);
      applyStimulus(8'h13);
      checkOutput("q19_error", 32'(error), 32'h1);
      checkOutput("q19_code", 32'(err_code), 32'h2);
      checkOutput("q19_nquant", 32'(Nquant), 32'd12);
      applyStimulus(8'hA5);
      applyStimulus(8'h02);
      applyStimulus(8'h0F);
      applyStimulus(8'h12);
      applyStimulus(8'h1F);
      checkOutput("q18_done", 32'(done), 32'h1);
      checkOutput("q18_nfreq", 32'(Nfreq), 32'hF);
      checkOutput("q18_nquant", 32'(Nquant), 32'd18);

      // Stall after two data bytes; error must land exactly 100 cycles later
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h04);
      applyStimulus(8'h20);
      sendData("to_d0", 8'h55, 7'h20);
      sendData("to_d1", 8'h66, 7'h21);
      quietErrors = 0;
      for (int i = 0; i < 99; i++) begin
         @(negedge clock);
         if (error !== 1'b0) quietErrors++;
      end
      checkOutput("to_no_early_error", 32'(quietErrors), 32'd0);
      checkOutput("to_busy_still", 32'(busy), 32'h1);
      @(negedge clock);
      checkOutput("to_error", 32'(error), 32'h1);
      checkOutput("to_code", 32'(err_code), 32'h3);
      checkOutput("to_busy", 32'(busy), 32'h0);
      checkOutput("to_last_write_addr", 32'(RAM_coefs_wr_addr), 32'h21);
      applyStimulus(8'hA5);
      applyStimulus(8'h02);
      applyStimulus(8'h05);
      applyStimulus(8'h0C);
      applyStimulus(8'h0B);
      checkOutput("to_recover_done", 32'(done), 32'h1);
      checkOutput("to_recover_nfreq", 32'(Nfreq), 32'h5);

      // Reset during DATA, then a clean frame; CK = 01^01^05^99 = 9C
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h04);
      applyStimulus(8'h30);
      sendData("rst_d0", 8'h77, 7'h30);
      reset = 1'b1;
      @(negedge clock);
      checkResetState("midreset");
      reset = 1'b0;
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h01);
      applyStimulus(8'h05);
      sendData("post_d0", 8'h99, 7'h05);
      applyStimulus(8'h9C);
      checkOutput("post_done", 32'(done), 32'h1);
      checkOutput("post_errcode", 32'(err_code), 32'h0);

      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
